gshare_predictor: RTL and testbench

Global-history (gshare) branch direction predictor with a direct-mapped branch target buffer. It is the consumer end of the branch-resolution interface `br_cntrl_bus_t`. At fetch it returns a same-cycle prediction (taken flag, target, GHR snapshot) for the current PC. It trains from resolved branches sent back by execute, which carry that snapshot. It uses the package types `GHR_t`, `cntr_pattern_t`, `btb_entry_t` and `br_cntrl_bus_t`.

---
 rtl/gshare_predictor.sv | 155 +++++++++++++++
 tb/tb_gshare_predictor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor with a direct-mapped BTB.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   pred_pc         fetch PC to predict
//   pred_taken      predicted taken (BTB hit and counter MSB set, only once ready)
//   pred_target     BTB target when predicted taken, otherwise pred_pc + 4
//   pred_ghr        committed GHR used for this prediction (travels with the instruction)
//   upd_valid       resolution strobe from execute
//   upd_bus         resolved branch: is_taken, branch_target, i_addr
//   upd_ghr         pred_ghr snapshot captured when the resolved branch was fetched
//   ready           tables initialised, predictions valid
//
// After reset an INIT sweep clears one counter and one BTB valid bit per cycle; the sweep
// counter is sized for the BTB, which is assumed to be at least as large as the counter
// table (counter index wraps modulo COUNTER_TABLE_SZ).

package gshare_pkg;

    typedef logic [7:0] GHR_t;

    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b10,
        STRONGLY_TAKEN     = 2'b11
    } cntr_pattern_t;

    typedef struct packed {
        logic [31:0] i_addr;
        logic [31:0] target_addr;
    } btb_entry_t;

    typedef struct packed {
        logic        is_taken;
        logic [31:0] branch_target;
        logic [31:0] i_addr;
    } br_cntrl_bus_t;

endpackage

module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int unsigned GHR_SIZE         = 8,
    parameter int unsigned COUNTER_TABLE_SZ = 1024,
    parameter int unsigned BTB_SIZE         = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pred_pc,
    output logic          pred_taken,
    output logic [31:0]   pred_target,
    output GHR_t          pred_ghr,
    input  logic          upd_valid,
    input  br_cntrl_bus_t upd_bus,
    input  GHR_t          upd_ghr,
    output logic          ready
);

    localparam int unsigned COUNTER_TABLE_BITS = $clog2(COUNTER_TABLE_SZ);
    localparam int unsigned BTB_BITS           = $clog2(BTB_SIZE);

    typedef enum logic {StInit, StRun} state_t;

    state_t                  r_state, w_state_next;
    logic [BTB_BITS-1:0]     r_sweep, w_sweep_next;
    GHR_t                    r_ghr;

    cntr_pattern_t           r_cntr      [COUNTER_TABLE_SZ];
    logic                    r_btb_valid [BTB_SIZE];
    btb_entry_t              r_btb       [BTB_SIZE];

    logic [COUNTER_TABLE_BITS-1:0] w_pred_idx, w_upd_idx;
    logic [BTB_BITS-1:0]           w_pred_slot, w_upd_slot;
    cntr_pattern_t                 w_pred_cntr, w_upd_cntr, w_cntr_next;
    logic                          w_ready, w_btb_hit, w_do_upd;

    // Index hashing: PC word address XOR zero-extended history.
    assign w_pred_idx  = pred_pc[COUNTER_TABLE_BITS+1:2] ^ COUNTER_TABLE_BITS'(r_ghr);
    assign w_upd_idx   = upd_bus.i_addr[COUNTER_TABLE_BITS+1:2] ^ COUNTER_TABLE_BITS'(upd_ghr);
    assign w_pred_slot = pred_pc[BTB_BITS+1:2];
    assign w_upd_slot  = upd_bus.i_addr[BTB_BITS+1:2];

    assign w_ready     = (r_state == StRun);
    assign w_pred_cntr = r_cntr[w_pred_idx];
    assign w_upd_cntr  = r_cntr[w_upd_idx];
    assign w_btb_hit   = r_btb_valid[w_pred_slot] && (r_btb[w_pred_slot].i_addr == pred_pc);
    assign w_do_upd    = upd_valid && w_ready;

    // Reads see the stored tables, so a same-cycle update is observed one cycle later.
    assign pred_taken  = w_ready && w_btb_hit && w_pred_cntr[1];
    assign pred_target = pred_taken ? r_btb[w_pred_slot].target_addr : pred_pc + 32'd4;
    assign pred_ghr    = r_ghr;
    assign ready       = w_ready;

    // Saturating 2-bit counter step.
    always_comb begin
        w_cntr_next = w_upd_cntr;
        if (upd_bus.is_taken) begin
            if (w_upd_cntr != STRONGLY_TAKEN) begin
                w_cntr_next = cntr_pattern_t'(w_upd_cntr + 2'd1);
            end
        end else begin
            if (w_upd_cntr != STRONGLY_NOT_TAKEN) begin
                w_cntr_next = cntr_pattern_t'(w_upd_cntr - 2'd1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sweep_next = r_sweep;
        case (r_state)
            StInit: begin
                w_sweep_next = r_sweep + 1'b1;
                if (r_sweep == BTB_BITS'(BTB_SIZE - 1)) begin
                    w_state_next = StRun;
                end
            end
            StRun:   w_state_next = StRun;
            default: w_state_next = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StInit;
            r_sweep <= '0;
            r_ghr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sweep <= w_sweep_next;
            if (w_do_upd) begin
                r_ghr <= {r_ghr[GHR_SIZE-2:0], upd_bus.is_taken};
            end
        end
    end

    // Table storage carries no reset; the INIT sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (r_state == StInit) begin
            r_cntr[r_sweep[COUNTER_TABLE_BITS-1:0]] <= WEAKLY_NOT_TAKEN;
            r_btb_valid[r_sweep]                    <= 1'b0;
        end else if (w_do_upd) begin
            r_cntr[w_upd_idx] <= w_cntr_next;
            if (upd_bus.is_taken) begin
                r_btb_valid[w_upd_slot] <= 1'b1;
                r_btb[w_upd_slot]       <= '{i_addr: upd_bus.i_addr,
                                             target_addr: upd_bus.branch_target};
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;
    import gshare_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    GHR_t          pred_ghr;
    logic          upd_valid;
    br_cntrl_bus_t upd_bus;
    GHR_t          upd_ghr;
    logic          ready;

    gshare_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_ghr    (pred_ghr),
        .upd_valid   (upd_valid),
        .upd_bus     (upd_bus),
        .upd_ghr     (upd_ghr),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: plain arrays indexed by the hashing rules.
    int          m_cnt   [1024];
    bit          m_valid [4096];
    logic [31:0] m_tag   [4096];
    logic [31:0] m_tgt   [4096];
    logic [7:0]  m_ghr;

    typedef struct {
        bit          upd;
        logic [31:0] pc;
        bit          tk;
        logic [31:0] tgt;
        logic [7:0]  ughr;
        bit          chk;
        bit          e_tk;
        logic [31:0] e_tgt;
        logic [7:0]  e_ghr;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 1024; i++) m_cnt[i] = 1;
        for (int i = 0; i < 4096; i++) m_valid[i] = 1'b0;
        m_ghr = 8'h00;
    endfunction

    function automatic int cidx(input logic [31:0] pc, input logic [7:0] g);
        logic [31:0] w;
        w = (pc >> 2) ^ {24'd0, g};
        return int'(w % 32'd1024);
    endfunction

    function automatic int bslot(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd4096);
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output bit tk,
                                          output logic [31:0] tgt);
        int  s;
        bit  hit;
        s   = bslot(pc);
        hit = m_valid[s] && (m_tag[s] == pc);
        tk  = hit && (m_cnt[cidx(pc, m_ghr)] >= 2);
        tgt = tk ? m_tgt[s] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit tk,
                                         input logic [31:0] tgt, input logic [7:0] ughr);
        int i;
        i = cidx(pc, ughr);
        if (tk) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        else    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        if (tk) begin
            m_valid[bslot(pc)] = 1'b1;
            m_tag[bslot(pc)]   = pc;
            m_tgt[bslot(pc)]   = tgt;
        end
        m_ghr = {m_ghr[6:0], tk};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input bit upd, input bit tk,
                         input logic [31:0] tgt, input logic [7:0] ughr);
        pred_pc               = pc;
        upd_valid             = upd;
        upd_bus.is_taken      = tk;
        upd_bus.branch_target = tgt;
        upd_bus.i_addr        = pc;
        upd_ghr               = ughr;
    endtask

    task automatic run_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                           input logic [7:0] ughr);
        drive(pc, 1'b1, tk, tgt, ughr);
        #1;
        model_update(pc, tk, tgt, ughr);
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input bit e_tk,
                            input logic [31:0] e_tgt, input logic [7:0] e_ghr);
        drive(pc, 1'b0, 1'b0, 32'h0, 8'h00);
        #1;
        check({name, "_taken"}, pred_taken, e_tk);
        check({name, "_target"}, pred_target, e_tgt);
        check({name, "_ghr"}, pred_ghr, e_ghr);
        tick();
    endtask

    // Release reset with a taken update held high, and count edges until ready.
    task automatic wait_ready(input string name);
        int n, bad_pred, bad_ghr;
        n        = 0;
        bad_pred = 0;
        bad_ghr  = 0;
        drive(32'h100, 1'b1, 1'b1, 32'h900, 8'h00);
        rst = 1'b0;
        #1;
        while (!ready && n < 5000) begin
            if (pred_taken !== 1'b0 || pred_target !== 32'h104) bad_pred++;
            if (pred_ghr !== 8'h00) bad_ghr++;
            @(posedge clk);
            #1;
            n++;
        end
        upd_valid = 1'b0;
        #1;
        check({name, "_edges"}, n, 4096);
        check({name, "_init_pred_bad"}, bad_pred, 0);
        check({name, "_init_ghr_bad"}, bad_ghr, 0);
        check({name, "_ready"}, ready, 1'b1);
        check({name, "_ghr_after"}, pred_ghr, 8'h00);
        tick();
    endtask

    function automatic void add(input bit upd, input logic [31:0] pc, input bit tk,
                                input logic [31:0] tgt, input logic [7:0] ughr, input bit chk,
                                input bit e_tk, input logic [31:0] e_tgt,
                                input logic [7:0] e_ghr, input string name);
        vec_t v;
        v = '{upd, pc, tk, tgt, ughr, chk, e_tk, e_tgt, e_ghr, name};
        vecs.push_back(v);
    endfunction

    initial begin
        bit          e_tk;
        logic [31:0] e_tgt;
        logic [31:0] pool [4];

        pool = '{32'h100, 32'h800, 32'h4100, 32'h1100};
        drive(32'h100, 1'b0, 1'b0, 32'h0, 8'h00);
        #2 rst = 1'b1;
        #1;
        check("reset_ready", ready, 1'b0);
        check("reset_taken", pred_taken, 1'b0);
        check("reset_target", pred_target, 32'h104);
        check("reset_ghr", pred_ghr, 8'h00);
        repeat (2) tick();

        wait_ready("init");
        model_reset();

        // Directed scenarios, applied in order.
        for (int i = 0; i < 8; i++) add(1, 32'h800, 1, 32'h900, 8'h00, 0, 0, 0, 0, "");
        add(0, 32'h100, 0, 0, 8'h00, 1, 0, 32'h104, 8'hFF, "ghr_8_taken");
        for (int i = 0; i < 2; i++) add(1, 32'h100, 1, 32'h200, 8'hFF, 0, 0, 0, 0, "");
        add(0, 32'h100, 0, 0, 8'h00, 1, 1, 32'h200, 8'hFF, "train_taken");
        add(1, 32'h100, 0, 0, 8'hFF, 0, 0, 0, 0, "");
        add(0, 32'h100, 0, 0, 8'h00, 1, 0, 32'h104, 8'hFE, "history_sens");
        for (int i = 0; i < 3; i++) add(1, 32'h100, 0, 0, 8'hE1, 0, 0, 0, 0, "");
        add(1, 32'h100, 1, 32'h200, 8'hE1, 0, 0, 0, 0, "");
        add(0, 32'h100, 0, 0, 8'h00, 1, 0, 32'h104, 8'hE1, "sat_low");
        add(1, 32'h100, 0, 0, 8'hFF, 0, 0, 0, 0, "");
        for (int i = 0; i < 8; i++) add(1, 32'h800, 1, 32'h900, 8'h00, 0, 0, 0, 0, "");
        add(1, 32'h100, 1, 32'h200, 8'hFF, 1, 0, 32'h104, 8'hFF, "simul_pre");
        add(0, 32'h100, 0, 0, 8'h00, 1, 1, 32'h200, 8'hFF, "simul_post");
        add(0, 32'h4100, 0, 0, 8'h00, 1, 0, 32'h4104, 8'hFF, "alias_tag_miss");

        foreach (vecs[k]) begin
            drive(vecs[k].pc, vecs[k].upd, vecs[k].tk, vecs[k].tgt, vecs[k].ughr);
            #1;
            if (vecs[k].chk) begin
                check({vecs[k].name, "_taken"}, pred_taken, vecs[k].e_tk);
                check({vecs[k].name, "_target"}, pred_target, vecs[k].e_tgt);
                check({vecs[k].name, "_ghr"}, pred_ghr, vecs[k].e_ghr);
            end
            if (vecs[k].upd) model_update(vecs[k].pc, vecs[k].tk, vecs[k].tgt, vecs[k].ughr);
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ppc, upc;
            logic [7:0]  ug;
            ppc = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)]
                                              : ($urandom & 32'h3FFC);
            upc = ($urandom_range(0, 2) != 0) ? pool[$urandom_range(0, 3)]
                                              : ($urandom & 32'h3FFC);
            ug  = ($urandom_range(0, 1) == 0) ? m_ghr : 8'($urandom);
            drive(upc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom & 32'hFFFF_FFFC, ug);
            pred_pc = ppc;
            #1;
            model_predict(ppc, e_tk, e_tgt);
            check("rand_pred", {pred_taken, pred_target, pred_ghr}, {e_tk, e_tgt, m_ghr});
            if (upd_valid) model_update(upc, upd_bus.is_taken, upd_bus.branch_target, ug);
            tick();
        end
        upd_valid = 1'b0;

        // Train a known entry, then reset asynchronously while ready.
        for (int i = 0; i < 8; i++) run_upd(32'h800, 1'b1, 32'h900, 8'h00);
        for (int i = 0; i < 2; i++) run_upd(32'h100, 1'b1, 32'h200, 8'hFF);
        chk_pred("pre_reset", 32'h100, 1'b1, 32'h200, 8'hFF);
        pred_pc = 32'h100;
        #1 rst = 1'b1;
        #1;
        check("async_rst_ready", ready, 1'b0);
        check("async_rst_ghr", pred_ghr, 8'h00);
        check("async_rst_taken", pred_taken, 1'b0);
        check("async_rst_target", pred_target, 32'h104);
        tick();

        // Abort an init sweep partway and confirm it restarts from zero.
        rst = 1'b0;
        repeat (1000) tick();
        check("mid_init_not_ready", ready, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        wait_ready("reinit");
        model_reset();

        // Counter for pc 0x100 gets trained via an alias with a different BTB slot;
        // a stale BTB entry for 0x100 would make it predict taken.
        for (int i = 0; i < 2; i++) run_upd(32'h1100, 1'b1, 32'h1200, 8'h03);
        chk_pred("btb_cleared", 32'h100, 1'b0, 32'h104, 8'h03);
        chk_pred("post_reinit_hit", 32'h1100, 1'b1, 32'h1200, 8'h03);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
